// File: rtl/axi_mem_window_slice.sv
// Two-entry skid buffer: main register feeds the sink, skid register absorbs the beat in flight when the sink stalls.
// Latency: a beat accepted at edge N is presented from cycle N+1.
// Backpressure: in_rdy is registered (skid empty); out_hold masks out_vld without losing the held entry.
module axi_mem_window_skid #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    input  logic         out_hold,
    output logic [W-1:0] out_dat
);
    logic         main_vld, skid_vld, live_q;
    logic [W-1:0] main_dat, skid_dat;
    logic         push, pop;

    // live_q keeps ready low while reset is held and for the reset edge itself
    assign in_rdy  = live_q & ~skid_vld;
    assign out_vld = main_vld & ~out_hold;
    assign out_dat = main_dat;
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    always_ff @(posedge clock) begin
        if (!reset) begin
            live_q   <= 1'b0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (pop || !main_vld) begin
                if (skid_vld) begin
                    main_vld <= 1'b1;
                    main_dat <= skid_dat;
                    skid_vld <= 1'b0;
                end else begin
                    main_vld <= push;
                    if (push) main_dat <= in_dat;
                end
            end else if (push) begin
                skid_vld <= 1'b1;
                skid_dat <= in_dat;
            end
        end
    end
endmodule

// Registered AXI4 slice CPU -> board memory: skid buffer on all five channels, low-DRAM window remap on AW/AR.
// Latency: one cycle per channel, 1 beat/cycle sustained.
// Backpressure: registered readies; AW/AR held back once MAX_OUT transactions are outstanding.
module axi_mem_window_slice #(
    parameter int                ADDR_W  = 40,
    parameter int                DATA_W  = 64,
    parameter int                ID_W    = 8,
    parameter logic [ADDR_W-32:0] SRC_HI = 'h1,
    parameter logic [ADDR_W-32:0] DST_HI = 'h90,
    parameter int                MAX_OUT = 8
) (
    input  logic                clock,
    input  logic                reset,
    // CPU side
    input  logic                s_awvalid,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic [ID_W-1:0]     s_awid,
    input  logic [7:0]          s_awlen,
    input  logic [2:0]          s_awsize,
    input  logic [1:0]          s_awburst,
    output logic                s_awready,
    input  logic                s_wvalid,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wlast,
    output logic                s_wready,
    output logic                s_bvalid,
    output logic [1:0]          s_bresp,
    output logic [ID_W-1:0]     s_bid,
    input  logic                s_bready,
    input  logic                s_arvalid,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic [ID_W-1:0]     s_arid,
    input  logic [7:0]          s_arlen,
    input  logic [2:0]          s_arsize,
    input  logic [1:0]          s_arburst,
    output logic                s_arready,
    output logic                s_rvalid,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic [ID_W-1:0]     s_rid,
    input  logic                s_rready,
    // memory side
    output logic                m_awvalid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [ID_W-1:0]     m_awid,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    input  logic                m_awready,
    output logic                m_wvalid,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    input  logic                m_wready,
    input  logic                m_bvalid,
    input  logic [1:0]          m_bresp,
    input  logic [ID_W-1:0]     m_bid,
    output logic                m_bready,
    output logic                m_arvalid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [ID_W-1:0]     m_arid,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    input  logic                m_arready,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic [ID_W-1:0]     m_rid,
    output logic                m_rready
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } ax_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
    } w_t;

    typedef struct packed {
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
    } b_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [ID_W-1:0]   id;
    } r_t;

    function automatic logic [ADDR_W-1:0] remap(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = a;
        if (a[ADDR_W-1:31] == SRC_HI) r[ADDR_W-1:31] = DST_HI;
        return r;
    endfunction

    ax_t aw_in, aw_out, ar_in, ar_out;
    w_t  w_in, w_out;
    b_t  b_in, b_out;
    r_t  r_in, r_out;

    logic [7:0] wcnt, rcnt;
    logic       aw_hold, ar_hold;
    logic       aw_inc, b_dec, ar_inc, r_dec;

    assign aw_in = '{remap(s_awaddr), s_awid, s_awlen, s_awsize, s_awburst};
    assign ar_in = '{remap(s_araddr), s_arid, s_arlen, s_arsize, s_arburst};
    assign w_in  = '{s_wdata, s_wstrb, s_wlast};
    assign b_in  = '{m_bresp, m_bid};
    assign r_in  = '{m_rdata, m_rresp, m_rlast, m_rid};

    assign {m_awaddr, m_awid, m_awlen, m_awsize, m_awburst} = aw_out;
    assign {m_araddr, m_arid, m_arlen, m_arsize, m_arburst} = ar_out;
    assign {m_wdata, m_wstrb, m_wlast}                      = w_out;
    assign {s_bresp, s_bid}                                 = b_out;
    assign {s_rdata, s_rresp, s_rlast, s_rid}               = r_out;

    assign aw_hold = (wcnt == 8'(MAX_OUT));
    assign ar_hold = (rcnt == 8'(MAX_OUT));

    axi_mem_window_skid #(.W($bits(ax_t))) u_aw (
        .clock(clock), .reset(reset),
        .in_vld(s_awvalid), .in_rdy(s_awready), .in_dat(aw_in),
        .out_vld(m_awvalid), .out_rdy(m_awready), .out_hold(aw_hold), .out_dat(aw_out)
    );

    axi_mem_window_skid #(.W($bits(w_t))) u_w (
        .clock(clock), .reset(reset),
        .in_vld(s_wvalid), .in_rdy(s_wready), .in_dat(w_in),
        .out_vld(m_wvalid), .out_rdy(m_wready), .out_hold(1'b0), .out_dat(w_out)
    );

    axi_mem_window_skid #(.W($bits(b_t))) u_b (
        .clock(clock), .reset(reset),
        .in_vld(m_bvalid), .in_rdy(m_bready), .in_dat(b_in),
        .out_vld(s_bvalid), .out_rdy(s_bready), .out_hold(1'b0), .out_dat(b_out)
    );

    axi_mem_window_skid #(.W($bits(ax_t))) u_ar (
        .clock(clock), .reset(reset),
        .in_vld(s_arvalid), .in_rdy(s_arready), .in_dat(ar_in),
        .out_vld(m_arvalid), .out_rdy(m_arready), .out_hold(ar_hold), .out_dat(ar_out)
    );

    axi_mem_window_skid #(.W($bits(r_t))) u_r (
        .clock(clock), .reset(reset),
        .in_vld(m_rvalid), .in_rdy(m_rready), .in_dat(r_in),
        .out_vld(s_rvalid), .out_rdy(s_rready), .out_hold(1'b0), .out_dat(r_out)
    );

    // Responses are counted at the CPU-side handshake so a slot frees only once the CPU has consumed it
    assign aw_inc = m_awvalid & m_awready;
    assign b_dec  = s_bvalid & s_bready;
    assign ar_inc = m_arvalid & m_arready;
    assign r_dec  = s_rvalid & s_rready & s_rlast;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wcnt <= 8'd0;
            rcnt <= 8'd0;
        end else begin
            if (aw_inc && !b_dec)                     wcnt <= wcnt + 8'd1;
            else if (!aw_inc && b_dec && wcnt != 8'd0) wcnt <= wcnt - 8'd1;
            if (ar_inc && !r_dec)                     rcnt <= rcnt + 8'd1;
            else if (!ar_inc && r_dec && rcnt != 8'd0) rcnt <= rcnt - 8'd1;
        end
    end

    wcnt_underflow: assert property (@(posedge clock) disable iff (!reset) !(b_dec && wcnt == 8'd0));
    rcnt_underflow: assert property (@(posedge clock) disable iff (!reset) !(r_dec && rcnt == 8'd0));
endmodule

// File: tb/tb_axi_mem_window_slice.sv
// Bench for axi_mem_window_slice: remap/passthrough vectors, streaming scoreboard, outstanding limit and reset cases.
module tb_axi_mem_window_slice;
    localparam int ADDR_W = 40, DATA_W = 64, ID_W = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic              s_awvalid = 0, s_awready;
    logic [ADDR_W-1:0] s_awaddr = '0;
    logic [ID_W-1:0]   s_awid = '0;
    logic [7:0]        s_awlen = '0;
    logic [2:0]        s_awsize = 3'd3;
    logic [1:0]        s_awburst = 2'b01;
    logic              s_wvalid = 0, s_wready, s_wlast = 0;
    logic [DATA_W-1:0] s_wdata = '0;
    logic [7:0]        s_wstrb = '0;
    logic              s_bvalid, s_bready = 0;
    logic [1:0]        s_bresp;
    logic [ID_W-1:0]   s_bid;
    logic              s_arvalid = 0, s_arready;
    logic [ADDR_W-1:0] s_araddr = '0;
    logic [ID_W-1:0]   s_arid = '0;
    logic [7:0]        s_arlen = '0;
    logic [2:0]        s_arsize = 3'd3;
    logic [1:0]        s_arburst = 2'b01;
    logic              s_rvalid, s_rlast, s_rready = 0;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic [ID_W-1:0]   s_rid;

    logic              m_awvalid, m_awready = 0;
    logic [ADDR_W-1:0] m_awaddr;
    logic [ID_W-1:0]   m_awid;
    logic [7:0]        m_awlen;
    logic [2:0]        m_awsize;
    logic [1:0]        m_awburst;
    logic              m_wvalid, m_wlast, m_wready = 0;
    logic [DATA_W-1:0] m_wdata;
    logic [7:0]        m_wstrb;
    logic              m_bvalid = 0, m_bready;
    logic [1:0]        m_bresp = '0;
    logic [ID_W-1:0]   m_bid = '0;
    logic              m_arvalid, m_arready = 0;
    logic [ADDR_W-1:0] m_araddr;
    logic [ID_W-1:0]   m_arid;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_rvalid = 0, m_rlast = 0, m_rready;
    logic [DATA_W-1:0] m_rdata = '0;
    logic [1:0]        m_rresp = '0;
    logic [ID_W-1:0]   m_rid = '0;

    axi_mem_window_slice dut (
        .clock(clock), .reset(reset),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
        .s_rready(s_rready),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
        .m_rready(m_rready)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        bit          wr;
        logic [39:0] addr;
        logic [7:0]  id;
        logic [7:0]  len;
        logic [39:0] exp_addr;
    } vec_t;

    vec_t vt[8];

    task automatic do_ar(input logic [39:0] addr, input logic [7:0] id, input logic [7:0] len,
                         input logic [39:0] exp_addr);
        check("ar_ready_idle", s_arready, 1);
        s_arvalid = 1; s_araddr = addr; s_arid = id; s_arlen = len;
        m_arready = 1; s_rready = 1;
        tick();
        s_arvalid = 0;
        check("ar_fwd_valid", m_arvalid, 1);
        check("ar_fwd_addr", m_araddr, exp_addr);
        check("ar_fwd_fields", {m_arid, m_arlen, m_arsize, m_arburst}, {id, len, 3'd3, 2'b01});
        tick();
        check("ar_fwd_once", m_arvalid, 0);
        check("rcnt_after_ar", dut.rcnt, 1);
        m_rvalid = 1; m_rdata = 64'hDEADBEEF; m_rresp = 2'b00; m_rlast = 1; m_rid = id;
        tick();
        m_rvalid = 0;
        check("r_ret_valid", s_rvalid, 1);
        check("r_ret_beat", {s_rdata, s_rresp, s_rlast, s_rid}, {64'hDEADBEEF, 2'b00, 1'b1, id});
        tick();
        check("r_ret_done", s_rvalid, 0);
        check("rcnt_after_r", dut.rcnt, 0);
    endtask

    task automatic do_aw(input logic [39:0] addr, input logic [7:0] id, input logic [7:0] len,
                         input logic [39:0] exp_addr);
        check("aw_ready_idle", s_awready, 1);
        s_awvalid = 1; s_awaddr = addr; s_awid = id; s_awlen = len;
        m_awready = 1; s_bready = 1;
        tick();
        s_awvalid = 0;
        check("aw_fwd_valid", m_awvalid, 1);
        check("aw_fwd_addr", m_awaddr, exp_addr);
        check("aw_fwd_fields", {m_awid, m_awlen, m_awsize, m_awburst}, {id, len, 3'd3, 2'b01});
        tick();
        check("aw_fwd_once", m_awvalid, 0);
        check("wcnt_after_aw", dut.wcnt, 1);
        m_bvalid = 1; m_bid = id; m_bresp = 2'b10;
        tick();
        m_bvalid = 0;
        check("b_ret", {s_bvalid, s_bresp, s_bid}, {1'b1, 2'b10, id});
        tick();
        check("b_ret_done", s_bvalid, 0);
        check("wcnt_after_b", dut.wcnt, 0);
    endtask

    // W flows CPU->memory, R flows memory->CPU; both scoreboarded against the order they were offered.
    task automatic run_stream(input int n, input bit rnd);
        logic [127:0] wq[$];
        logic [127:0] rq[$];
        int w_sent = 0, w_rcvd = 0, r_sent = 0, r_rcvd = 0;
        int cyc = 0, w_done = 0, r_done = 0;
        int budget;
        bit w_src, w_snk, r_src, r_snk;
        budget = n * 10 + 50;
        m_wready = 1; s_rready = 1;
        while ((w_rcvd < n || r_rcvd < n) && cyc < budget) begin
            w_src = s_wvalid && s_wready;
            w_snk = m_wvalid && m_wready;
            r_src = m_rvalid && m_rready;
            r_snk = s_rvalid && s_rready;
            if (w_src) begin wq.push_back({s_wlast, s_wstrb, s_wdata}); w_sent++; end
            if (r_src) begin rq.push_back({m_rid, m_rresp, m_rlast, m_rdata}); r_sent++; end
            if (w_snk) begin
                if (wq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL w_extra_beat: got beat %0h, expected none", m_wdata);
                end else check("w_beat", {m_wlast, m_wstrb, m_wdata}, wq.pop_front());
                w_rcvd++;
            end
            if (r_snk) begin
                if (rq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL r_extra_beat: got beat %0h, expected none", s_rdata);
                end else check("r_beat", {s_rid, s_rresp, s_rlast, s_rdata}, rq.pop_front());
                r_rcvd++;
            end
            tick();
            cyc++;
            if (w_rcvd == n && w_done == 0) w_done = cyc;
            if (r_rcvd == n && r_done == 0) r_done = cyc;
            if (!s_wvalid || w_src) begin
                if (w_sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
                    s_wvalid = 1;
                    s_wdata  = 64'h1000_0000_0000_0000 + 64'(w_sent);
                    s_wstrb  = 8'(w_sent);
                    s_wlast  = 1'(w_sent & 1);
                end else s_wvalid = 0;
            end
            if (!m_rvalid || r_src) begin
                if (r_sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
                    m_rvalid = 1;
                    m_rdata  = 64'h2000_0000_0000_0000 + 64'(r_sent);
                    m_rresp  = 2'(r_sent);
                    m_rid    = 8'(r_sent * 3);
                    m_rlast  = 0;
                end else m_rvalid = 0;
            end
            m_wready = !rnd || ($urandom_range(0, 3) != 0);
            s_rready = !rnd || ($urandom_range(0, 3) != 0);
        end
        check("w_beats_delivered", w_rcvd, n);
        check("r_beats_delivered", r_rcvd, n);
        check("w_queue_drained", wq.size(), 0);
        check("r_queue_drained", rq.size(), 0);
        if (!rnd) begin
            check("w_full_rate_cycles", w_done, n + 2);
            check("r_full_rate_cycles", r_done, n + 2);
        end
        s_wvalid = 0; m_rvalid = 0; m_wready = 1; s_rready = 1;
    endtask

    int sent, fwd;

    initial begin
        vt[0] = '{1'b0, 40'h00_8000_1000, 8'd3, 8'd0,   40'h48_0000_1000};
        vt[1] = '{1'b1, 40'h00_1000_0000, 8'd1, 8'd0,   40'h00_1000_0000};
        vt[2] = '{1'b0, 40'h00_FFFF_FFFF, 8'd2, 8'd7,   40'h48_7FFF_FFFF};
        vt[3] = '{1'b1, 40'h00_8000_0040, 8'd4, 8'd15,  40'h48_0000_0040};
        vt[4] = '{1'b0, 40'h01_0000_0000, 8'd5, 8'd1,   40'h01_0000_0000};
        vt[5] = '{1'b1, 40'h48_0000_0000, 8'd6, 8'd3,   40'h48_0000_0000};
        vt[6] = '{1'b0, 40'hFF_FFFF_FFFF, 8'd7, 8'd255, 40'hFF_FFFF_FFFF};
        vt[7] = '{1'b1, 40'h00_7FFF_FFFF, 8'd8, 8'd2,   40'h00_7FFF_FFFF};

        // reset held with a pending AW: nothing handshakes, nothing leaks out
        s_awvalid = 1; s_awaddr = 40'h00_8000_0000;
        repeat (3) begin
            tick();
            check("rst_readies", {s_awready, s_wready, s_arready, m_bready, m_rready}, 0);
            check("rst_valids", {m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}, 0);
        end
        reset = 1;
        tick();
        s_awvalid = 0;
        check("rel_readies", {s_awready, s_wready, s_arready, m_bready, m_rready}, 5'h1f);
        repeat (3) begin
            tick();
            check("rel_no_aw", m_awvalid, 0);
        end

        foreach (vt[i]) begin
            if (vt[i].wr) do_aw(vt[i].addr, vt[i].id, vt[i].len, vt[i].exp_addr);
            else          do_ar(vt[i].addr, vt[i].id, vt[i].len, vt[i].exp_addr);
        end

        run_stream(20, 1'b0);
        run_stream(1000, 1'b1);

        // outstanding write limit: B withheld, only MAX_OUT AWs may pass
        m_awready = 1; s_bready = 1; sent = 0; fwd = 0;
        s_awvalid = 1; s_awaddr = 40'h00_8000_0000; s_awid = 8'd0; s_awlen = 8'd0;
        for (int c = 0; c < 30; c++) begin
            if (s_awvalid && s_awready) sent++;
            if (m_awvalid && m_awready) fwd++;
            tick();
            if (sent >= 16) s_awvalid = 0;
            else s_awid = 8'(sent);
        end
        check("limit_fwd_count", fwd, 8);
        check("limit_accepted", sent, 10);
        check("limit_awvalid_low", m_awvalid, 0);
        check("limit_awready_low", s_awready, 0);
        check("limit_wcnt", dut.wcnt, 8);
        m_bvalid = 1; m_bid = 8'd0; m_bresp = 2'b00;
        tick();
        m_bvalid = 0;
        check("limit_b_out", s_bvalid, 1);
        check("limit_still_held", m_awvalid, 0);
        tick();
        check("limit_ninth_aw", {m_awvalid, m_awid}, {1'b1, 8'd8});
        tick();
        check("limit_held_again", m_awvalid, 0);
        check("limit_wcnt_again", dut.wcnt, 8);
        s_awvalid = 0;

        // reset during an R burst
        s_arvalid = 1; s_araddr = 40'h00_8000_2000; s_arid = 8'd5; s_arlen = 8'd3; m_arready = 1;
        tick();
        s_arvalid = 0;
        tick();
        check("burst_rcnt", dut.rcnt, 1);
        s_rready = 1; m_rvalid = 1; m_rdata = 64'h0; m_rlast = 0; m_rid = 8'd5;
        tick();
        m_rdata = 64'h1;
        tick();
        check("burst_beat2_out", {s_rvalid, s_rdata}, {1'b1, 64'h1});
        reset = 0; m_rvalid = 0;
        tick();
        check("burst_rst_rvalid", s_rvalid, 0);
        check("burst_rst_others", {m_awvalid, m_arvalid, s_bvalid, m_wvalid}, 0);
        reset = 1;
        tick();
        check("burst_rcnt_cleared", dut.rcnt, 0);
        check("burst_wcnt_cleared", dut.wcnt, 0);
        do_ar(40'h00_8000_3000, 8'd7, 8'd0, 40'h48_0000_3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
